// File: rtl/demux_pkg.sv
// Shared types and constants for the 4-way destination demux dispatcher.
package demux_pkg;

  localparam int DATA_W   = 4;
  localparam int SEL_W    = 2;
  localparam int NUM_DEST = 4;

  localparam logic [SEL_W-1:0] DEST_LIB    = 2'd0;
  localparam logic [SEL_W-1:0] DEST_FIRE   = 2'd1;
  localparam logic [SEL_W-1:0] DEST_SCHOOL = 2'd2;
  localparam logic [SEL_W-1:0] DEST_RIB    = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ASSERT} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  dest;
  } cmd_t;

  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_DEST-1:0] oh;
    oh = '0;
    case (sel)
      DEST_LIB:    oh[0] = 1'b1;
      DEST_FIRE:   oh[1] = 1'b1;
      DEST_SCHOOL: oh[2] = 1'b1;
      DEST_RIB:    oh[3] = 1'b1;
      default:     oh    = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_cmd_fifo.sv
// Command FIFO: DEPTH entries of {data, dest}, occupancy counter, wrapping pointers.
module demux_cmd_fifo
  import demux_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  cmd_t                   wr_cmd,
  input  logic                   pop,
  output cmd_t                   rd_cmd,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign rd_cmd = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_cmd;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W + 1)'(1);
      else if (pop && !push) count <= count - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Dispatcher for the 4-way destination demux: queues commands and delivers them
// one at a time, holding Enable only once the addressed destination is ready.
module demux_dispatch_ctrl
  import demux_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      InData,
  input  logic [SEL_W-1:0]       InDest,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [NUM_DEST-1:0]    DestReady,
  output logic [DATA_W-1:0]      DataOut,
  output logic [SEL_W-1:0]       SelOut,
  output logic                   EnableOut,
  output logic [NUM_DEST-1:0]    Delivered,
  output logic                   Busy,
  output logic [$clog2(DEPTH):0] FifoCount
);

  localparam int                HOLD_W    = 4;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(1);

  state_t            state, state_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              enable_d;
  logic              push, pop, full, empty;
  cmd_t              in_cmd, head;

  assign in_cmd  = '{data: InData, dest: InDest};
  assign InReady = !full;
  // Full is judged on start-of-cycle occupancy, so a same-cycle pop never frees a slot early.
  assign push    = InValid && !full;

  demux_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_cmd (in_cmd),
    .pop    (pop),
    .rd_cmd (head),
    .full   (full),
    .empty  (empty),
    .count  (FifoCount)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    hold_d   = hold_cnt;
    enable_d = 1'b0;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP, WAIT: begin
        if (DestReady[SelOut]) begin
          state_d  = ASSERT;
          hold_d   = HOLD_LOAD;
          enable_d = 1'b1;
        end else begin
          state_d  = WAIT;
        end
      end
      ASSERT: begin
        if (hold_cnt == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_d   = hold_cnt - HOLD_W'(1);
          enable_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // DataOut/SelOut load only on IDLE->SETUP, so they are frozen whenever Enable is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      EnableOut <= 1'b0;
      DataOut   <= '0;
      SelOut    <= '0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_d;
      EnableOut <= enable_d;
      if (pop) begin
        DataOut <= head.data;
        SelOut  <= head.dest;
      end
    end
  end

  assign Delivered = (state == ASSERT && hold_cnt == HOLD_LAST) ? dest_onehot(SelOut) : '0;
  assign Busy      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: directed vector table, hand-written corner sequences,
// and random traffic against a timeline-based reference model.
module tb_demux_dispatch_ctrl;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] InData = '0;
  logic [1:0] InDest = '0;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [3:0] DestReady = '0;
  logic [3:0] DataOut;
  logic [1:0] SelOut;
  logic       EnableOut;
  logic [3:0] Delivered;
  logic       Busy;
  logic [2:0] FifoCount;

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .InData    (InData),
    .InDest    (InDest),
    .InValid   (InValid),
    .InReady   (InReady),
    .DestReady (DestReady),
    .DataOut   (DataOut),
    .SelOut    (SelOut),
    .EnableOut (EnableOut),
    .Delivered (Delivered),
    .Busy      (Busy),
    .FifoCount (FifoCount)
  );

  typedef struct packed {
    logic       rdy;
    logic [2:0] cnt;
    logic       busy;
    logic       en;
    logic [3:0] del;
    logic [3:0] data;
    logic [1:0] sel;
  } outs_t;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] dest;
  } tcmd_t;

  typedef struct {
    logic       valid;
    logic [3:0] data;
    logic [1:0] dest;
    logic [3:0] rdy;
    outs_t      exp;
  } vec_t;

  typedef struct {
    int         c;
    logic [3:0] d;
    logic [1:0] s;
  } dlog_t;

  int    n_vec = 0;
  int    n_err = 0;
  outs_t last;
  vec_t  tab[$];
  dlog_t del_log[$];
  tcmd_t pushed[$];

  // Reference model: a queue of accepted commands plus the timeline of the delivery
  // in progress (the cycle its destination was first seen ready).
  tcmd_t      q[$];
  bit         m_active;
  int         m_ready_cyc;
  logic [3:0] m_data;
  logic [1:0] m_sel;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic outs_t actual();
    outs_t a;
    a.rdy = InReady;  a.cnt = FifoCount; a.busy = Busy; a.en = EnableOut;
    a.del = Delivered; a.data = DataOut; a.sel = SelOut;
    return a;
  endfunction

  function automatic outs_t mk_out(input logic r, input logic [2:0] c, input logic b,
                                   input logic e, input logic [3:0] dl,
                                   input logic [3:0] d, input logic [1:0] s);
    outs_t o;
    o.rdy = r; o.cnt = c; o.busy = b; o.en = e; o.del = dl; o.data = d; o.sel = s;
    return o;
  endfunction

  function automatic vec_t mk_vec(input logic v, input logic [3:0] d, input logic [1:0] s,
                                  input logic [3:0] rdy, input outs_t e);
    vec_t x;
    x.valid = v; x.data = d; x.dest = s; x.rdy = rdy; x.exp = e;
    return x;
  endfunction

  function automatic outs_t model_expect();
    outs_t e;
    bit    on;
    on     = m_active && m_ready_cyc >= 0 && cyc > m_ready_cyc && cyc <= m_ready_cyc + HOLD;
    e.rdy  = q.size() < DEPTH;
    e.cnt  = 3'(q.size());
    e.busy = m_active || q.size() > 0;
    e.en   = on;
    e.del  = (on && cyc == m_ready_cyc + HOLD) ? 4'(1 << m_sel) : 4'b0;
    e.data = m_data;
    e.sel  = m_sel;
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_active = 0; m_ready_cyc = -1; m_data = '0; m_sel = '0;
  endtask

  task automatic model_advance();
    bit    do_push, do_pop, was_active;
    int    size0;
    tcmd_t c;
    size0      = q.size();
    was_active = m_active;
    do_push    = InValid && size0 < DEPTH;
    do_pop     = !was_active && size0 > 0;
    if (was_active && m_ready_cyc < 0 && DestReady[m_sel]) m_ready_cyc = cyc;
    else if (was_active && m_ready_cyc >= 0 && cyc == m_ready_cyc + HOLD) m_active = 0;
    if (do_pop) begin
      m_data = q[0].data; m_sel = q[0].dest;
      void'(q.pop_front());
      m_active = 1; m_ready_cyc = -1;
    end
    if (do_push) begin
      c.data = InData; c.dest = InDest;
      q.push_back(c);
      pushed.push_back(c);
    end
    cyc++;
  endtask

  // Called just after a rising edge: drive inputs, sample and compare mid-cycle, advance model.
  task automatic run_cycle(input logic v, input logic [3:0] d, input logic [1:0] s,
                           input logic [3:0] rdy);
    dlog_t e;
    InValid = v; InData = d; InDest = s; DestReady = rdy;
    @(negedge clk);
    last = actual();
    check("model", 32'(last), 32'(model_expect()));
    if (last.del != 4'b0) begin
      e.c = cyc; e.d = last.data; e.s = last.sel;
      del_log.push_back(e);
    end
    model_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single delivery to school, then to rib shack, all destinations ready.
    tab.push_back(mk_vec(1, 4'hA, 2'd2, 4'hF, mk_out(1, 0, 0, 0, 4'h0, 4'h0, 2'd0)));
    tab.push_back(mk_vec(0, 4'h0, 2'd0, 4'hF, mk_out(1, 1, 1, 0, 4'h0, 4'h0, 2'd0)));
    tab.push_back(mk_vec(0, 4'h0, 2'd0, 4'hF, mk_out(1, 0, 1, 0, 4'h0, 4'hA, 2'd2)));
    tab.push_back(mk_vec(0, 4'h0, 2'd0, 4'hF, mk_out(1, 0, 1, 1, 4'h0, 4'hA, 2'd2)));
    tab.push_back(mk_vec(0, 4'h0, 2'd0, 4'hF, mk_out(1, 0, 1, 1, 4'h4, 4'hA, 2'd2)));
    tab.push_back(mk_vec(0, 4'h0, 2'd0, 4'hF, mk_out(1, 0, 0, 0, 4'h0, 4'hA, 2'd2)));
    tab.push_back(mk_vec(1, 4'h5, 2'd3, 4'hF, mk_out(1, 0, 0, 0, 4'h0, 4'hA, 2'd2)));
    tab.push_back(mk_vec(0, 4'h0, 2'd0, 4'hF, mk_out(1, 1, 1, 0, 4'h0, 4'hA, 2'd2)));
    tab.push_back(mk_vec(0, 4'h0, 2'd0, 4'hF, mk_out(1, 0, 1, 0, 4'h0, 4'h5, 2'd3)));
    tab.push_back(mk_vec(0, 4'h0, 2'd0, 4'hF, mk_out(1, 0, 1, 1, 4'h0, 4'h5, 2'd3)));
    tab.push_back(mk_vec(0, 4'h0, 2'd0, 4'hF, mk_out(1, 0, 1, 1, 4'h8, 4'h5, 2'd3)));
    tab.push_back(mk_vec(0, 4'h0, 2'd0, 4'hF, mk_out(1, 0, 0, 0, 4'h0, 4'h5, 2'd3)));

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(actual()), 32'(mk_out(1, 0, 0, 0, 4'h0, 4'h0, 2'd0)));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tab[i]) begin
      run_cycle(tab[i].valid, tab[i].data, tab[i].dest, tab[i].rdy);
      check($sformatf("table[%0d]", i), 32'(last), 32'(tab[i].exp));
    end

    // Reset in the middle of a delivery.
    run_cycle(1, 4'h6, 2'd0, 4'hF);
    run_cycle(1, 4'h7, 2'd1, 4'hF);
    run_cycle(0, 4'h0, 2'd0, 4'hF);
    check("pre_reset_en", 32'(EnableOut), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_en", 32'(EnableOut), 32'(0));
    check("async_count", 32'(FifoCount), 32'(0));
    check("async_deliv", 32'(Delivered), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    run_cycle(0, 4'h0, 2'd0, 4'hF);
    check("ready_after_reset", 32'(last.rdy), 32'(1));
    check("no_deliv_after_reset", 32'(last.del), 32'(0));

    // Fire dept not ready while other destinations are; delivery waits.
    run_cycle(1, 4'h7, 2'd1, 4'b1101);
    for (int i = 0; i < 6; i++) begin
      run_cycle(0, 4'h0, 2'd0, 4'b1101);
      check("wait_en_low", 32'(last.en), 32'(0));
    end
    run_cycle(0, 4'h0, 2'd0, 4'b0010);
    check("en_at_ready", 32'(last.en), 32'(0));
    run_cycle(0, 4'h0, 2'd0, 4'b0000);
    check("en_after_ready", 32'(last.en), 32'(1));
    run_cycle(0, 4'h0, 2'd0, 4'b0000);
    check("deliver_fire", 32'(last.del), 32'(4'b0010));
    repeat (2) run_cycle(0, 4'h0, 2'd0, 4'h0);

    // Head-of-line block: no destination ready, InValid held until the FIFO is full.
    pushed.delete();
    del_log.delete();
    for (int i = 0; i < 7; i++)
      run_cycle(1, 4'(pushed.size()), 2'(pushed.size()), 4'h0);
    check("full_count", 32'(last.cnt), 32'(DEPTH));
    check("full_inready", 32'(last.rdy), 32'(0));

    // Release all destinations while continuing to push, then drain.
    for (int i = 0; i < 40; i++)
      run_cycle(1, 4'(pushed.size()), 2'(pushed.size()), 4'hF);
    for (int i = 0; i < 30; i++)
      run_cycle(0, 4'h0, 2'd0, 4'hF);
    check("deliv_count", 32'(del_log.size()), 32'(pushed.size()));
    foreach (del_log[i]) begin
      if (i < pushed.size()) begin
        check("order_data", 32'(del_log[i].d), 32'(pushed[i].data));
        check("order_dest", 32'(del_log[i].s), 32'(pushed[i].dest));
      end
      if (i > 0) check("period", 32'(del_log[i].c - del_log[i-1].c), 32'(HOLD + 2));
    end

    // Push on the same edge as the IDLE pop of a single queued command.
    del_log.delete();
    run_cycle(1, 4'h3, 2'd3, 4'hF);
    run_cycle(1, 4'h9, 2'd1, 4'hF);
    run_cycle(0, 4'h0, 2'd0, 4'hF);
    check("push_pop_count", 32'(last.cnt), 32'(1));
    for (int i = 0; i < 10; i++) run_cycle(0, 4'h0, 2'd0, 4'hF);
    check("pp_deliv_count", 32'(del_log.size()), 32'(2));
    if (del_log.size() == 2) begin
      check("pp_first", 32'(del_log[0].d), 32'(4'h3));
      check("pp_second", 32'(del_log[1].d), 32'(4'h9));
      check("pp_second_dest", 32'(del_log[1].s), 32'(2'd1));
    end

    // Random traffic against the model.
    for (int i = 0; i < 800; i++)
      run_cycle(1'($urandom), 4'($urandom), 2'($urandom), 4'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
